// File: rtl/game_pkg.sv
// game_pkg: shared player command encodings and per-key debounce states.
package game_pkg;
    typedef enum logic [1:0] {
        COMMAND_NONE  = 2'd0,
        COMMAND_HIT   = 2'd1,
        COMMAND_STAND = 2'd2,
        COMMAND_DEAL  = 2'd3
    } gameCommand;
    typedef enum logic [1:0] {
        DB_UP        = 2'd0,
        DB_DOWN_WAIT = 2'd1,
        DB_DOWN      = 2'd2,
        DB_UP_WAIT   = 2'd3
    } debounce_state_e;
endpackage

// File: rtl/player_input_ctrl_if.sv
// player_input_ctrl_if: push-button inputs and command handshake of one player's input controller.
import game_pkg::*;
interface player_input_ctrl_if #(parameter int NUM_KEYS = 3);
    logic                i_turnIndicator;
    logic [NUM_KEYS-1:0] i_KEY;
    logic                i_cmd_ack;
    logic [NUM_KEYS-1:0] o_keyDown;
    logic [NUM_KEYS-1:0] o_keyPress;
    logic                o_dealButtonPushed;
    logic                o_cmd_valid;
    gameCommand          o_command;
    modport master (
        output i_turnIndicator, i_KEY, i_cmd_ack,
        input  o_keyDown, o_keyPress, o_dealButtonPushed, o_cmd_valid, o_command
    );
    modport slave (
        input  i_turnIndicator, i_KEY, i_cmd_ack,
        output o_keyDown, o_keyPress, o_dealButtonPushed, o_cmd_valid, o_command
    );
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchronizer and debounce FSM for one active-low button.
// Defining PLAYER_INPUT_AUTOREPEAT_EN adds a press re-pulse every REPEAT_CYCLES while held.
module key_debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1048576
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    , parameter int REPEAT_CYCLES = 2097152
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_down,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0]      sync_q, sync_d;
    debounce_state_e state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            key;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_hit;
`endif
    assign key = sync_q[1];
    always_comb begin
        sync_d  = {sync_q[0], ~i_key_n};
        state_d = state_q;
        case (state_q)
            DB_UP:        state_d = key ? DB_DOWN_WAIT : DB_UP;
            DB_DOWN_WAIT: state_d = !key ? DB_UP : (cnt_q == CNT_LAST) ? DB_DOWN : DB_DOWN_WAIT;
            DB_DOWN:      state_d = key ? DB_DOWN : DB_UP_WAIT;
            default:      state_d = key ? DB_DOWN : (cnt_q == CNT_LAST) ? DB_UP : DB_UP_WAIT;
        endcase
        // the counter restarts on every state entry and saturates while a level is stable
        cnt_d   = (state_d != state_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        press_d = (state_q == DB_DOWN_WAIT) && (state_d == DB_DOWN);
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
        rep_hit = (state_q == DB_DOWN) && (state_d == DB_DOWN) && (rep_q == RW'(REPEAT_CYCLES - 1));
        rep_d   = (state_q != DB_DOWN || state_d != DB_DOWN || rep_hit) ? '0 :
                  (rep_q == RW'(REPEAT_CYCLES)) ? rep_q : rep_q + 1'b1;
        press_d = press_d || rep_hit;
`endif
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q  <= '0;
            state_q <= DB_UP;
            cnt_q   <= '0;
            press_q <= 1'b0;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end
    assign o_down  = (state_q == DB_DOWN) || (state_q == DB_UP_WAIT);
    assign o_press = press_q;
endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: debounced player buttons turned into a single pending HIT/STAND command.
// Defining PLAYER_INPUT_AUTOREPEAT_EN enables auto-repeat of held keys.
module player_input_ctrl
    import game_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1048576,
    parameter int KEY_HIT         = 0,
    parameter int KEY_STAND       = 1,
    parameter int KEY_DEAL        = 2,
    parameter int REPEAT_CYCLES   = 2097152
) (
    input  logic             i_clk,
    input  logic             i_reset,
    player_input_ctrl_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;
    logic [NUM_KEYS-1:0] down, press;
    logic [0:0]          state_q, state_d;
    gameCommand          cmd_q, cmd_d;
    if (NUM_KEYS < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_cfg_err
        $error("player_input_ctrl: parameter out of range");
    end
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
            , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_db (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_key_n (bus.i_KEY[k]),
            .o_down  (down[k]),
            .o_press (press[k])
        );
    end
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        if (state_q == ST_IDLE) begin
            if (bus.i_turnIndicator && (press[KEY_STAND] || press[KEY_HIT])) begin
                state_d = ST_PENDING;
                cmd_d   = press[KEY_STAND] ? COMMAND_STAND : COMMAND_HIT;
            end
        end else if (bus.i_cmd_ack || !bus.i_turnIndicator) begin
            state_d = ST_IDLE;
            cmd_d   = COMMAND_NONE;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= COMMAND_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end
    assign bus.o_keyDown          = down;
    assign bus.o_keyPress         = press;
    assign bus.o_dealButtonPushed = press[KEY_DEAL];
    assign bus.o_cmd_valid        = (state_q == ST_PENDING);
    assign bus.o_command          = cmd_q;
endmodule

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: directed stimulus with a queue-based scoreboard for press pulses and commands.
module tb_player_input_ctrl;
    import game_pkg::*;
    typedef struct { int cyc; logic [2:0] mask; } press_t;
    typedef struct { int cyc; gameCommand cmd; } cmd_t;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
    localparam int REPS = 4;
`else
    localparam int REPS = 1;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    press_t     pq[$];
    cmd_t       cq[$];
    press_t     pe;
    cmd_t       ce;
    gameCommand exp_cmd = COMMAND_NONE;
    logic       prev_valid = 1'b0;
    int         n0;

    player_input_ctrl_if #(.NUM_KEYS(3)) dut_if ();

    player_input_ctrl #(
        .NUM_KEYS(3), .DEBOUNCE_CYCLES(4), .KEY_HIT(0), .KEY_STAND(1), .KEY_DEAL(2), .REPEAT_CYCLES(8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_keyDown"}, dut_if.o_keyDown, 0);
        chk({tag, "_keyPress"}, dut_if.o_keyPress, 0);
        chk({tag, "_deal"}, dut_if.o_dealButtonPushed, 0);
        chk({tag, "_valid"}, dut_if.o_cmd_valid, 0);
        chk({tag, "_command"}, dut_if.o_command, COMMAND_NONE);
    endtask

    task automatic ack();
        dut_if.i_cmd_ack = 1'b1;
        tick(1);
        dut_if.i_cmd_ack = 1'b0;
        chk("valid_after_ack", dut_if.o_cmd_valid, 0);
    endtask

    task automatic expect_press(input int c, input logic [2:0] m);
        pq.push_back('{cyc: c, mask: m});
    endtask

    task automatic expect_cmd(input int c, input gameCommand cmd);
        cq.push_back('{cyc: c, cmd: cmd});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.o_keyPress != 3'b000 || dut_if.o_dealButtonPushed) begin
                if (pq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL press_unexpected: keyPress=%b deal=%b at cycle %0d, none expected",
                             dut_if.o_keyPress, dut_if.o_dealButtonPushed, cyc);
                end else begin
                    pe = pq.pop_front();
                    chk("press_mask", dut_if.o_keyPress, pe.mask);
                    chk("press_cycle", cyc, pe.cyc);
                    chk("deal_pulse", dut_if.o_dealButtonPushed, pe.mask[2]);
                end
            end
            if (dut_if.o_cmd_valid && !prev_valid) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: command=%0d at cycle %0d, none expected", dut_if.o_command, cyc);
                    exp_cmd = dut_if.o_command;
                end else begin
                    ce = cq.pop_front();
                    chk("cmd_value", dut_if.o_command, ce.cmd);
                    chk("cmd_cycle", cyc, ce.cyc);
                    exp_cmd = ce.cmd;
                end
            end else if (dut_if.o_cmd_valid) begin
                chk("cmd_hold", dut_if.o_command, exp_cmd);
            end else begin
                chk("cmd_none", dut_if.o_command, COMMAND_NONE);
            end
        end
        prev_valid = dut_if.o_cmd_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        dut_if.i_KEY = 3'b111;
        dut_if.i_turnIndicator = 1'b0;
        dut_if.i_cmd_ack = 1'b0;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(3);

        // clean HIT press on our turn, held pending until acknowledged
        dut_if.i_turnIndicator = 1'b1;
        dut_if.i_KEY[0] = 1'b0;
        expect_press(cyc + 7, 3'b001);
        expect_cmd(cyc + 8, COMMAND_HIT);
        tick(10);
        dut_if.i_KEY[0] = 1'b1;
        tick(10);
        chk("hit_held_valid", dut_if.o_cmd_valid, 1);
        ack();
        tick(12);

        // bouncing STAND then stable
        dut_if.i_KEY[1] = 1'b0; tick(1);
        dut_if.i_KEY[1] = 1'b1; tick(1);
        dut_if.i_KEY[1] = 1'b0; tick(1);
        dut_if.i_KEY[1] = 1'b1; tick(1);
        dut_if.i_KEY[1] = 1'b0;
        expect_press(cyc + 7, 3'b010);
        expect_cmd(cyc + 8, COMMAND_STAND);
        tick(10);
        dut_if.i_KEY[1] = 1'b1;
        ack();
        tick(12);

        // HIT and STAND together, then another HIT while pending
        dut_if.i_KEY[1:0] = 2'b00;
        expect_press(cyc + 7, 3'b011);
        expect_cmd(cyc + 8, COMMAND_STAND);
        tick(10);
        dut_if.i_KEY[1:0] = 2'b11;
        tick(10);
        dut_if.i_KEY[0] = 1'b0;
        expect_press(cyc + 7, 3'b001);
        tick(10);
        dut_if.i_KEY[0] = 1'b1;
        chk("pending_still_valid", dut_if.o_cmd_valid, 1);
        chk("pending_still_stand", dut_if.o_command, COMMAND_STAND);
        ack();
        tick(12);
        chk("no_queued_cmd", dut_if.o_cmd_valid, 0);

        // not our turn: DEAL still pulses, HIT gives no command
        dut_if.i_turnIndicator = 1'b0;
        dut_if.i_KEY[2] = 1'b0;
        expect_press(cyc + 7, 3'b100);
        tick(10);
        dut_if.i_KEY[2] = 1'b1;
        tick(12);
        dut_if.i_KEY[0] = 1'b0;
        expect_press(cyc + 7, 3'b001);
        tick(10);
        dut_if.i_KEY[0] = 1'b1;
        tick(12);
        chk("off_turn_no_cmd", dut_if.o_cmd_valid, 0);

        // reset in DOWN_WAIT and in PENDING with the key held throughout
        dut_if.i_turnIndicator = 1'b1;
        dut_if.i_KEY[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        check_zero("rst_dwait");
        rst = 1'b0;
        expect_press(cyc + 7, 3'b001);
        expect_cmd(cyc + 8, COMMAND_HIT);
        tick(10);
        chk("pre_rst_pending", dut_if.o_cmd_valid, 1);
        rst = 1'b1;
        tick(1);
        check_zero("rst_pending");
        rst = 1'b0;
        expect_press(cyc + 7, 3'b001);
        expect_cmd(cyc + 8, COMMAND_HIT);
        tick(10);
        dut_if.i_KEY[0] = 1'b1;
        ack();
        tick(12);

        // HIT held for 30 cycles, every command acknowledged
        n0 = cyc;
        dut_if.i_KEY[0] = 1'b0;
        for (int k = 0; k < REPS; k++) begin
            expect_press(n0 + 7 + 8 * k, 3'b001);
            expect_cmd(n0 + 8 + 8 * k, COMMAND_HIT);
        end
        tick(8);
        for (int k = 0; k < REPS; k++) begin
            ack();
            if (k < REPS - 1) tick(7);
        end
        while (cyc < n0 + 30) tick(1);
        dut_if.i_KEY[0] = 1'b1;
        tick(15);

        chk("press_queue_empty", pq.size(), 0);
        chk("cmd_queue_empty", cq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
